// File: rtl/axis_protocol_monitor.sv
// Passive AXI-Stream protocol monitor: sticky error flags, irq, saturating beat/packet counters.
// Latency: an offending cycle shows in err_flags/err_irq/counters one cycle later. Backpressure: none, it never drives the link.
// Optional stall timeout check is compiled in with `define AXIS_MON_TIMEOUT_EN.
module axis_protocol_monitor #(
  parameter int DATA_WIDTH     = 8,
  parameter int ID_WIDTH       = 1,
  parameter int DEST_WIDTH     = 1,
  parameter int USER_WIDTH     = 1,
  parameter int MAX_PKT_BEATS  = 1024,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_WIDTH-1:0]   mon_data,
  input  logic [ID_WIDTH-1:0]     mon_id,
  input  logic [DEST_WIDTH-1:0]   mon_dest,
  input  logic [USER_WIDTH-1:0]   mon_user,
  input  logic [DATA_WIDTH/8-1:0] mon_keep,
  input  logic                    mon_last,
  input  logic                    mon_valid,
  input  logic                    mon_ready,
  input  logic                    clear,
  output logic [6:0]              err_flags,
  output logic                    err_irq,
  output logic                    in_packet,
  output logic [CNT_WIDTH-1:0]    beat_cnt,
  output logic [CNT_WIDTH-1:0]    pkt_cnt
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int PW = DATA_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH + KW + 1;
  localparam int CW = ID_WIDTH + DEST_WIDTH;
  localparam int BW = $clog2(MAX_PKT_BEATS + 2);

  typedef enum logic {IDLE, IN_PKT} state_e;

  state_e                state_q, state_d;
  logic [BW-1:0]         pkt_beats_q, pkt_beats_d;
  logic [CW-1:0]         cap_q, cap_d;
  logic                  p_hold_q;
  logic [PW-1:0]         p_payload_q;
  logic [6:0]            flags_q, flags_d;
  logic                  irq_q, irq_d;
  logic [CNT_WIDTH-1:0]  beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  pkt_q, pkt_d;

  logic                  acc;
  logic [PW-1:0]         payload;
  logic [CW-1:0]         id_dest;
  logic [KW-1:0]         keep_inc;
  logic                  keep_contig;
  logic                  timeout_hit;
  logic [6:0]            err_new;

`ifdef AXIS_MON_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
  logic [TW-1:0] stall_q, stall_d;

  // Saturating one past the limit makes each stall match the limit exactly once.
  always_comb begin
    stall_d = '0;
    if (mon_valid & ~mon_ready) begin
      stall_d = (stall_q == TW'(TIMEOUT_CYCLES + 1)) ? stall_q : stall_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign timeout_hit = (stall_q == TW'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    acc         = mon_valid & mon_ready;
    payload     = {mon_data, mon_id, mon_dest, mon_user, mon_keep, mon_last};
    id_dest     = {mon_id, mon_dest};
    keep_inc    = mon_keep + KW'(1);
    keep_contig = ((mon_keep & keep_inc) == '0);

    err_new    = '0;
    err_new[0] = p_hold_q & ~mon_valid;
    err_new[1] = p_hold_q & mon_valid & (payload != p_payload_q);
    err_new[2] = acc & (mon_keep == '0);
    err_new[3] = acc & ((~mon_last & ~(&mon_keep)) |
                        (mon_last & (mon_keep != '0) & ~keep_contig));
    err_new[4] = acc & (state_q == IN_PKT) & (id_dest != cap_q);
    // With a one-beat limit, a non-last opening beat already overruns.
    err_new[5] = acc & ~mon_last &
                 ((state_q == IDLE) ? (MAX_PKT_BEATS == 1)
                                    : ((MAX_PKT_BEATS > 1) && (pkt_beats_q == BW'(MAX_PKT_BEATS))));
    err_new[6] = timeout_hit;
  end

  always_comb begin
    state_d     = state_q;
    pkt_beats_d = pkt_beats_q;
    cap_d       = cap_q;
    case (state_q)
      IDLE: begin
        if (acc & ~mon_last) begin
          state_d     = IN_PKT;
          cap_d       = id_dest;
          pkt_beats_d = BW'(1);
        end
      end
      IN_PKT: begin
        if (acc & mon_last) begin
          state_d = IDLE;
        end else if (acc && (pkt_beats_q != BW'(MAX_PKT_BEATS + 1))) begin
          pkt_beats_d = pkt_beats_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Set and increment take priority over a same-cycle clear.
  always_comb begin
    flags_d = (clear ? 7'd0 : flags_q) | err_new;
    irq_d   = |flags_d;
    beat_d  = clear ? '0 : beat_q;
    pkt_d   = clear ? '0 : pkt_q;
    if (acc && (beat_d != '1)) beat_d = beat_d + CNT_WIDTH'(1);
    if (acc && mon_last && (pkt_d != '1)) pkt_d = pkt_d + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pkt_beats_q <= '0;
      cap_q       <= '0;
      p_hold_q    <= 1'b0;
      p_payload_q <= '0;
      flags_q     <= '0;
      irq_q       <= 1'b0;
      beat_q      <= '0;
      pkt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pkt_beats_q <= pkt_beats_d;
      cap_q       <= cap_d;
      p_hold_q    <= mon_valid & ~mon_ready;
      p_payload_q <= payload;
      flags_q     <= flags_d;
      irq_q       <= irq_d;
      beat_q      <= beat_d;
      pkt_q       <= pkt_d;
    end
  end

  assign err_flags = flags_q;
  assign err_irq   = irq_q;
  assign in_packet = (state_q == IN_PKT);
  assign beat_cnt  = beat_q;
  assign pkt_cnt   = pkt_q;

endmodule

// File: tb/tb_axis_protocol_monitor.sv
// Bench for axis_protocol_monitor: directed vector table, corner sequences, randomized run against a reference model.
module tb_axis_protocol_monitor;

  localparam int DW    = 32;
  localparam int IW    = 2;
  localparam int DSW   = 2;
  localparam int UW    = 2;
  localparam int KW    = DW / 8;
  localparam int MAXB  = 4;
  localparam int CNTW  = 8;
  localparam int TOC   = 8;
  localparam int CMAX  = (1 << CNTW) - 1;
`ifdef AXIS_MON_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic [DW-1:0]   mon_data;
  logic [IW-1:0]   mon_id;
  logic [DSW-1:0]  mon_dest;
  logic [UW-1:0]   mon_user;
  logic [KW-1:0]   mon_keep;
  logic            mon_last, mon_valid, mon_ready, clear;
  logic [6:0]      err_flags;
  logic            err_irq, in_packet;
  logic [CNTW-1:0] beat_cnt, pkt_cnt;

  axis_protocol_monitor #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW),
    .MAX_PKT_BEATS(MAXB), .CNT_WIDTH(CNTW), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mon_data(mon_data), .mon_id(mon_id),
    .mon_dest(mon_dest), .mon_user(mon_user), .mon_keep(mon_keep),
    .mon_last(mon_last), .mon_valid(mon_valid), .mon_ready(mon_ready),
    .clear(clear), .err_flags(err_flags), .err_irq(err_irq),
    .in_packet(in_packet), .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 50) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [6:0] ef, input int bc, input int pc, input bit ip);
    chk({tag, " err_flags"}, 32'(err_flags), 32'(ef));
    chk({tag, " err_irq"},   32'(err_irq),   32'(|ef));
    chk({tag, " in_packet"}, 32'(in_packet), 32'(ip));
    chk({tag, " beat_cnt"},  32'(beat_cnt),  32'(bc));
    chk({tag, " pkt_cnt"},   32'(pkt_cnt),   32'(pc));
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic drv(input bit v, input bit r, input logic [DW-1:0] d, input logic [IW-1:0] id,
                     input logic [DSW-1:0] ds, input logic [UW-1:0] u, input logic [KW-1:0] k,
                     input bit l, input bit c);
    mon_valid = v; mon_ready = r; mon_data = d; mon_id = id; mon_dest = ds;
    mon_user = u; mon_keep = k; mon_last = l; clear = c;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit v, r; logic [DW-1:0] d; logic [IW-1:0] id; logic [KW-1:0] k; bit l, c;
    logic [6:0] ef; int bc, pc; bit ip;
  } vec_t;

  function automatic vec_t mk(bit v, bit r, logic [DW-1:0] d, logic [IW-1:0] id, logic [KW-1:0] k,
                              bit l, bit c, logic [6:0] ef, int bc, int pc, bit ip);
    vec_t t;
    t.v = v; t.r = r; t.d = d; t.id = id; t.k = k; t.l = l; t.c = c;
    t.ef = ef; t.bc = bc; t.pc = pc; t.ip = ip;
    return t;
  endfunction

  // Reference model: per-packet beat list, run length of stalls, sticky flag word.
  logic [6:0]  m_flags;
  int          m_beat, m_pkt, m_run;
  bit          m_hold;
  logic [DW+IW+DSW+UW+KW:0] m_payload;
  int          m_pkt_ids[$];

  function automatic bit last_keep_ok(logic [KW-1:0] k);
    bit gap = 0;
    for (int i = 0; i < KW; i++) begin
      if (!k[i]) gap = 1;
      else if (gap) return 0;
    end
    return 1;
  endfunction

  task automatic model_reset();
    m_flags = '0; m_beat = 0; m_pkt = 0; m_run = 0; m_hold = 0; m_payload = '0;
    m_pkt_ids.delete();
  endtask

  task automatic model_step(input bit v, input bit r, input logic [DW-1:0] d, input logic [IW-1:0] id,
                            input logic [DSW-1:0] ds, input logic [UW-1:0] u, input logic [KW-1:0] k,
                            input bit l, input bit c);
    logic [6:0] nw = '0;
    bit acc = v & r;
    int iddest = int'({id, ds});
    logic [DW+IW+DSW+UW+KW:0] pl = {d, id, ds, u, k, l};
    if (m_hold && !v) nw[0] = 1;
    if (m_hold && v && pl != m_payload) nw[1] = 1;
    if (acc && k == '0) nw[2] = 1;
    if (acc && !l && k != '1) nw[3] = 1;
    if (acc && l && k != '0 && !last_keep_ok(k)) nw[3] = 1;
    if (acc && m_pkt_ids.size() > 0 && iddest != m_pkt_ids[0]) nw[4] = 1;
    if (acc && !l && m_pkt_ids.size() + 1 == MAXB + 1) nw[5] = 1;
    if (TO_EN && m_run == TOC) nw[6] = 1;
    m_flags = (c ? 7'd0 : m_flags) | nw;
    if (c) begin m_beat = 0; m_pkt = 0; end
    if (acc) m_beat = (m_beat == CMAX) ? CMAX : m_beat + 1;
    if (acc && l) m_pkt = (m_pkt == CMAX) ? CMAX : m_pkt + 1;
    if (acc) begin
      if (l) m_pkt_ids.delete();
      else m_pkt_ids.push_back(iddest);
    end
    m_hold = v & ~r;
    m_payload = pl;
    m_run = (v && !r) ? m_run + 1 : 0;
  endtask

  vec_t tbl[$];

  initial begin
    logic [6:0] exp6;
    // Directed vectors: {valid, ready, data, id, keep, last, clear} -> {flags, beats, pkts, in_packet}
    tbl.push_back(mk(1,0,32'hA5,0,4'hF,1,0, 7'h00,0,0,0));
    tbl.push_back(mk(1,0,32'hA5,0,4'hF,1,0, 7'h00,0,0,0));
    tbl.push_back(mk(1,0,32'hA5,0,4'hF,1,0, 7'h00,0,0,0));
    tbl.push_back(mk(1,1,32'hA5,0,4'hF,1,0, 7'h00,1,1,0));
    tbl.push_back(mk(0,0,32'h00,0,4'hF,0,0, 7'h00,1,1,0));
    tbl.push_back(mk(1,0,32'h11,0,4'hF,1,0, 7'h00,1,1,0));
    tbl.push_back(mk(1,0,32'h22,0,4'hF,1,0, 7'h02,1,1,0));
    tbl.push_back(mk(1,1,32'h22,0,4'hF,1,0, 7'h02,2,2,0));
    tbl.push_back(mk(0,0,32'h00,0,4'hF,0,1, 7'h00,0,0,0));
    tbl.push_back(mk(1,1,32'h00,0,4'h7,0,0, 7'h08,1,0,1));
    tbl.push_back(mk(1,1,32'h00,0,4'h5,1,0, 7'h08,2,1,0));
    tbl.push_back(mk(0,0,32'h00,0,4'hF,0,1, 7'h00,0,0,0));
    tbl.push_back(mk(1,1,32'h00,0,4'h3,1,0, 7'h00,1,1,0));
    tbl.push_back(mk(1,1,32'h00,0,4'h5,1,0, 7'h08,2,2,0));
    tbl.push_back(mk(1,1,32'h00,0,4'h0,1,0, 7'h0C,3,3,0));
    tbl.push_back(mk(0,0,32'h00,0,4'hF,0,1, 7'h00,0,0,0));
    tbl.push_back(mk(1,1,32'h01,0,4'hF,0,0, 7'h00,1,0,1));
    tbl.push_back(mk(1,1,32'h02,0,4'hF,0,0, 7'h00,2,0,1));
    tbl.push_back(mk(1,1,32'h03,1,4'hF,1,0, 7'h10,3,1,0));
    tbl.push_back(mk(0,0,32'h00,0,4'hF,0,1, 7'h00,0,0,0));
    for (int b = 1; b <= 4; b++) tbl.push_back(mk(1,1,32'(b),0,4'hF,0,0, 7'h00,b,0,1));
    tbl.push_back(mk(1,1,32'h05,0,4'hF,0,0, 7'h20,5,0,1));
    tbl.push_back(mk(1,1,32'h06,0,4'hF,1,1, 7'h00,1,1,0));
    tbl.push_back(mk(0,0,32'h00,0,4'hF,0,1, 7'h00,0,0,0));
    tbl.push_back(mk(1,0,32'h00,0,4'hF,1,0, 7'h00,0,0,0));
    tbl.push_back(mk(0,0,32'h00,0,4'hF,1,0, 7'h01,0,0,0));
    tbl.push_back(mk(1,0,32'hAA,0,4'hF,1,0, 7'h01,0,0,0));
    tbl.push_back(mk(1,1,32'hBB,0,4'h5,0,0, 7'h0B,1,0,1));
    tbl.push_back(mk(1,1,32'hCC,0,4'hF,1,0, 7'h0B,2,1,0));
    tbl.push_back(mk(0,0,32'h00,0,4'hF,0,1, 7'h00,0,0,0));

    reset_n = 1'b0;
    mon_valid = 0; mon_ready = 0; mon_data = '0; mon_id = '0; mon_dest = '0;
    mon_user = '0; mon_keep = '0; mon_last = 0; clear = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 7'h00, 0, 0, 0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      drv(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].id, '0, '0, tbl[i].k, tbl[i].l, tbl[i].c);
      chk_all($sformatf("vec%0d", i), tbl[i].ef, tbl[i].bc, tbl[i].pc, tbl[i].ip);
    end

    // Stall of TIMEOUT-1 cycles must not flag.
    for (int i = 0; i < TOC - 1; i++) drv(1,0,32'h5A,0,0,0,4'hF,1,0);
    drv(1,1,32'h5A,0,0,0,4'hF,1,0);
    drv(0,0,0,0,0,0,4'hF,0,0);
    chk_all("stall7", 7'h00, 1, 1, 0);
    drv(0,0,0,0,0,0,4'hF,0,1);

    // Stall of exactly TIMEOUT cycles flags once timeout is built in.
    for (int i = 0; i < TOC; i++) drv(1,0,32'h5A,0,0,0,4'hF,1,0);
    drv(1,1,32'h5A,0,0,0,4'hF,1,0);
    exp6 = TO_EN ? 7'h40 : 7'h00;
    chk_all("stall8", exp6, 1, 1, 0);
    drv(0,0,0,0,0,0,4'hF,0,0);
    chk_all("stall8_hold", exp6, 1, 1, 0);
    drv(0,0,0,0,0,0,4'hF,0,1);

    // Reset mid-packet, mid-stall: everything returns to zero, no drop flagged after release.
    drv(1,1,32'h77,1,0,0,4'hF,0,0);
    chk("midpkt in_packet", 32'(in_packet), 32'd1);
    for (int i = 0; i < 5; i++) drv(1,0,32'h78,1,0,0,4'hF,0,0);
    reset_n = 1'b0;
    #2;
    chk_all("async_reset", 7'h00, 0, 0, 0);
    @(posedge clk);
    #1;
    mon_valid = 0;
    reset_n = 1'b1;
    drv(0,0,0,0,0,0,4'hF,0,0);
    chk_all("post_reset", 7'h00, 0, 0, 0);

    // Randomized run against the reference model.
    begin
      bit v = 0, r = 0, l = 0, c = 0;
      logic [DW-1:0] d = '0;
      logic [IW-1:0] id = '0;
      logic [DSW-1:0] ds = '0;
      logic [UW-1:0] u = '0;
      logic [KW-1:0] k = '1;
      logic [KW-1:0] kset [6] = '{4'hF, 4'hF, 4'h7, 4'h3, 4'h1, 4'h5};
      int stall_left = 0;
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      model_reset();
      for (int n = 0; n < 3000; n++) begin
        if (!(v && !r && ($urandom % 12 != 0))) begin
          v = ($urandom % 4) != 0;
          d = $urandom;
          if ($urandom % 10 == 0) id = IW'($urandom);
          if ($urandom % 10 == 0) ds = DSW'($urandom);
          u = UW'($urandom);
          k = ($urandom % 20 == 0) ? 4'h0 : kset[$urandom % 6];
          l = ($urandom % 4) == 0;
        end
        if (stall_left > 0) begin
          r = 0;
          stall_left--;
        end else begin
          r = ($urandom % 3) != 0;
          if ($urandom % 40 == 0) stall_left = $urandom_range(6, 11);
        end
        c = ($urandom % 60) == 0;
        drv(v, r, d, id, ds, u, k, l, c);
        model_step(v, r, d, id, ds, u, k, l, c);
        chk_all($sformatf("rnd%0d", n), m_flags, m_beat, m_pkt, m_pkt_ids.size() > 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_protocol_monitor.md
# axis_protocol_monitor

Synthesizable, passive AXI-Stream protocol monitor for one link, parametrised in payload widths and packet limits. It sits beside any AXIS interface in the switch datapath or at chip-level ports and observes without driving. It checks handshake stability, TKEEP legality, ID/DEST consistency within a packet, packet length and stall duration. It reports sticky error flags, an interrupt line and saturating beat/packet counters.

## Interface
- DATA_WIDTH, 8, payload width in bits; multiple of 8, ≥ 8
- ID_WIDTH, 1, TID width
- DEST_WIDTH, 1, TDEST width
- USER_WIDTH, 1, TUSER width
- MAX_PKT_BEATS, 1024, max legal beats per packet, ≥ 1
- CNT_WIDTH, 32, width of statistics counters
- TIMEOUT_CYCLES, 256, stall limit, ≥ 2; used only with the timeout feature

- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- mon_data  in  DATA_WIDTH  observed TDATA
- mon_id  in  ID_WIDTH  observed TID
- mon_dest  in  DEST_WIDTH  observed TDEST
- mon_user  in  USER_WIDTH  observed TUSER
- mon_keep  in  DATA_WIDTH/8  observed TKEEP
- mon_last  in  1  observed TLAST
- mon_valid  in  1  observed TVALID
- mon_ready  in  1  observed TREADY
- clear  in  1  synchronous clear of flags and counters
- err_flags  out  7  sticky error bits, see Operation
- err_irq  out  1  OR of err_flags, registered
- in_packet  out  1  1 while in state IN_PKT
- beat_cnt  out  CNT_WIDTH  accepted beats, saturating
- pkt_cnt  out  CNT_WIDTH  accepted last beats, saturating

## Operation
- Accepted beat (acc) = mon_valid & mon_ready.
- Registers p_hold (previous cycle valid & ~ready) and p_payload ({data,id,dest,user,keep,last} of that cycle).
- FSM IDLE / IN_PKT:
  - IDLE: acc & ~last -> IN_PKT; capture id/dest; pkt_beats = 1.
  - IDLE: acc & last -> stay IDLE (single-beat packet).
  - IN_PKT: acc & last -> IDLE; acc & ~last -> pkt_beats += 1, saturating at MAX_PKT_BEATS+1.
- err_flags bits, each set by its condition and held until clear:
  - [0] VALID_DROP: p_hold & ~mon_valid.
  - [1] PAYLOAD_CHANGE: p_hold & mon_valid & payload ≠ p_payload.
  - [2] KEEP_ZERO: acc & keep == 0.
  - [3] KEEP_SPARSE: acc & ~last & keep ≠ all-ones, or acc & last & keep nonzero and not of form 2^k−1.
  - [4] ID_DEST_CHANGE: IN_PKT & acc & {id,dest} ≠ captured value.
  - [5] PKT_TOO_LONG: acc & ~last with pkt_beats == MAX_PKT_BEATS, i.e. beat MAX_PKT_BEATS+1 lacks last. Flags once per packet; tracking continues until last.
  - [6] STALL_TIMEOUT: see Configuration.
- beat_cnt increments on every acc; pkt_cnt increments on acc & last. Both hold at all-ones.
- Monitor never drives link signals; mon_ready is an input only.

## Timing
- Reset values: err_flags = 0, err_irq = 0, in_packet = 0, beat_cnt = 0, pkt_cnt = 0, FSM IDLE, p_hold = 0, stall counter = 0.
- Latency: an offending cycle N sets its err_flags bit and err_irq at N+1. Counters update at N+1.
- clear at N: flags and counters read 0 at N+1. FSM, pkt_beats, p_hold and captured id/dest are unaffected.
- clear and a new error or acc in the same cycle: the new error bit is set, and the counter reads 1 (set/increment wins over clear).
- Reset mid-packet returns to IDLE. p_hold = 0, so the first cycle after release cannot raise VALID_DROP or PAYLOAD_CHANGE.
- Multiple errors in one cycle set all their bits simultaneously.
- With MAX_PKT_BEATS = 1, any acc & ~last flags PKT_TOO_LONG.

## Configuration
- Macro AXIS_MON_TIMEOUT_EN.
- Defined:
  - The stall counter increments each cycle of mon_valid & ~mon_ready and resets to 0 otherwise.
  - When the counter reaches TIMEOUT_CYCLES, err_flags[6] is set on the next cycle. The counter then saturates, so one stall flags once.
- Undefined: no stall counter; err_flags[6] tied to 0; TIMEOUT_CYCLES ignored.

## Test plan
- Valid 1, ready 0 for 3 cycles, data held at 0xA5, then ready 1 -> err_flags == 0; beat_cnt == 1; pkt_cnt == 1 if last = 1.
- Valid 1, ready 0 at cycle N, data changes 0x11 -> 0x22 at N+1 -> err_flags[1] = 1 and err_irq = 1 at N+2.
- DATA_WIDTH 32:
  - Non-last beat with keep 4'b0111 -> bit 3 set.
  - Last beat with keep 4'b0101 -> bit 3 set.
  - Last beat with keep 4'b0011 -> no error.
- 3-beat packet with id 0,0,1 -> bit 4 set at the third beat + 1; pkt_cnt == 1; in_packet 0 after the last beat.
- MAX_PKT_BEATS 4, 6-beat packet -> bit 5 set one cycle after beat 5, flagged once; assert clear while beat 6 is accepted -> beat_cnt reads 1 and bit 5 reads 0.
- With AXIS_MON_TIMEOUT_EN and TIMEOUT_CYCLES 8:
  - Stall 7 cycles -> no flag.
  - Stall 8 cycles -> bit 6 set.
  - Assert reset_n low mid-stall -> all outputs 0 and no error after release.
